// File: rtl/hi_lo_unit.sv
// HI/LO register unit: holds a multi-cycle multiply result captured from the upstream
// multiplier and serves MFHI/MFLO reads, stalling the pipeline while the multiply runs.
module hi_lo_unit #(
  parameter int         MUL_CYCLES = 32,
  parameter logic [2:0] MULTU      = 3'b100,
  parameter logic [2:0] MFHI       = 3'b101,
  parameter logic [2:0] MFLO       = 3'b110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  signal,
  input  logic [63:0] mulAns,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  // state | meaning
  // IDLE  | no multiply in flight; MFHI/MFLO served, MULTU accepted
  // BUSY  | waiting MUL_CYCLES edges for the multiplier; reads held off
  // DONE  | hi/lo just loaded; behaves as IDLE for one cycle
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int             CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(MUL_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   hi, lo;
  logic          capture;
  logic          read_hi, read_lo;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE, DONE: begin
        cnt_nxt = '0;
        if (signal == MULTU) state_nxt = BUSY;
        else                 state_nxt = IDLE;
      end
      BUSY: begin
        // The operation length is fixed; a repeated MULTU here never restarts it.
        if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign read_hi = (state != BUSY) && (signal == MFHI);
  assign read_lo = (state != BUSY) && (signal == MFLO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      dataOut <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        hi <= mulAns[63:32];
        lo <= mulAns[31:0];
      end
      if (read_hi)      dataOut <= hi;
      else if (read_lo) dataOut <= lo;
    end
  end

  assign busy  = (state == BUSY);
  assign done  = (state == DONE);
  assign stall = busy && ((signal == MULTU) || (signal == MFHI) || (signal == MFLO));

endmodule
